// File: rtl/complex_acc_stage_pkg.sv
// complex_acc_stage_pkg: shared FSM state type and overflow helper for the accumulator stage
package complex_acc_stage_pkg;

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    // A two's-complement add overflowed when the guard bit disagrees with the lane sign bit.
    function automatic logic add_ovf(input logic guard, input logic msb);
        return guard ^ msb;
    endfunction

endpackage

// File: rtl/complex_acc_stage_sat_add.sv
// complex_sat_add: one lane of sign-extending saturating accumulate
//   i_acc  [ACC_W-1:0]  running signed sum
//   i_in   [IN_W-1:0]   signed addend, sign-extended to ACC_W
//   o_sum  [ACC_W-1:0]  sum clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]
//   o_ovf               the clamp was applied
module complex_sat_add
    import complex_acc_stage_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int ACC_W = 34
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [IN_W-1:0]  i_in,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_ovf
);

    logic [ACC_W:0] w_full;

    assign w_full = {i_acc[ACC_W-1], i_acc} + {{(ACC_W + 1 - IN_W){i_in[IN_W-1]}}, i_in};
    assign o_ovf  = add_ovf(w_full[ACC_W], w_full[ACC_W-1]);
    // The guard bit holds the true sign, so it selects the min or max rail.
    assign o_sum  = o_ovf ? {w_full[ACC_W], {(ACC_W - 1){~w_full[ACC_W]}}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/complex_acc_stage.sv
// complex_acc_stage: sums N_ACC complex products per frame with saturation, valid/ready output
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_in_valid / o_in_ready     product input handshake
//   i_prod_re, i_prod_im        signed product lanes, 2*WIDTH bits
//   i_clear                     synchronous abort of the current frame and any pending result
//   o_out_valid / i_out_ready   frame result handshake
//   o_acc_re, o_acc_im          signed frame sum, ACC_W bits
//   o_out_ovf                   a lane saturated somewhere in the reported frame
module complex_acc_stage
    import complex_acc_stage_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_ACC = 8,
    parameter int ACC_W = 2 * WIDTH + 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_in_valid,
    output logic               o_in_ready,
    input  logic [2*WIDTH-1:0] i_prod_re,
    input  logic [2*WIDTH-1:0] i_prod_im,
    input  logic               i_clear,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [ACC_W-1:0]   o_acc_re,
    output logic [ACC_W-1:0]   o_acc_im,
    output logic               o_out_ovf
);

    localparam int CW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_ACC - 1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_count;
    logic [ACC_W-1:0] r_sum_re, r_sum_im, r_acc_re, r_acc_im;
    logic             r_ovf, r_out_ovf;
    logic [ACC_W-1:0] w_sum_re, w_sum_im;
    logic             w_ovf_re, w_ovf_im, w_take, w_last;

    complex_sat_add #(.IN_W(2 * WIDTH), .ACC_W(ACC_W)) u_re (
        .i_acc(r_sum_re), .i_in(i_prod_re), .o_sum(w_sum_re), .o_ovf(w_ovf_re)
    );
    complex_sat_add #(.IN_W(2 * WIDTH), .ACC_W(ACC_W)) u_im (
        .i_acc(r_sum_im), .i_in(i_prod_im), .o_sum(w_sum_im), .o_ovf(w_ovf_im)
    );

    assign w_take = i_in_valid && o_in_ready;
    assign w_last = r_count == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ACCUM;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = i_clear                          ? ACCUM :
                 (w_take && w_last)               ? HOLD  :
                 (r_state == HOLD && i_out_ready) ? ACCUM : r_state;
    end

    always_comb begin
        o_in_ready  = r_state == ACCUM;
        o_out_valid = r_state == HOLD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_sum_re  <= '0;
            r_sum_im  <= '0;
            r_ovf     <= 1'b0;
            r_acc_re  <= '0;
            r_acc_im  <= '0;
            r_out_ovf <= 1'b0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_sum_re <= '0;
            r_sum_im <= '0;
            r_ovf    <= 1'b0;
        end else if (w_take && w_last) begin
            r_count   <= '0;
            r_sum_re  <= '0;
            r_sum_im  <= '0;
            r_ovf     <= 1'b0;
            r_acc_re  <= w_sum_re;
            r_acc_im  <= w_sum_im;
            r_out_ovf <= r_ovf | w_ovf_re | w_ovf_im;
        end else if (w_take) begin
            r_count  <= r_count + CW'(1);
            r_sum_re <= w_sum_re;
            r_sum_im <= w_sum_im;
            r_ovf    <= r_ovf | w_ovf_re | w_ovf_im;
        end
    end

    assign o_acc_re  = r_acc_re;
    assign o_acc_im  = r_acc_im;
    assign o_out_ovf = r_out_ovf;

endmodule

// File: tb/tb_complex_acc_stage.sv
// tb_complex_acc_stage: directed vector table, async reset sequence and random frames vs a reference model
module tb_complex_acc_stage;

    localparam int     N      = 4;
    localparam longint MAXV   = 64'sd4294967295;
    localparam longint MINV   = -64'sd4294967296;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_in_valid = 1'b0, i_clear = 1'b0, i_out_ready = 1'b0;
    logic [31:0] i_prod_re = '0, i_prod_im = '0;
    logic        o_in_ready, o_out_valid, o_out_ovf;
    logic [32:0] o_acc_re, o_acc_im;

    complex_acc_stage #(.WIDTH(16), .N_ACC(N), .ACC_W(33)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_prod_re(i_prod_re), .i_prod_im(i_prod_im),
        .i_clear(i_clear),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_acc_re(o_acc_re), .o_acc_im(o_acc_im), .o_out_ovf(o_out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, c, r;
        logic [31:0] pre, pim;
        logic        e_ov, e_ir;
        longint      e_re, e_im;
        logic        e_of;
    } vec_t;

    typedef struct {
        longint re, im;
        logic   ovf;
    } frame_t;

    vec_t   tbl[$];
    frame_t exp_q[$];
    int     checks = 0, errors = 0;
    logic   m_hold = 1'b0, m_ovf = 1'b0;
    longint m_re = 0, m_im = 0;
    int     m_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic c, input logic r, input logic [31:0] pre,
                       input logic [31:0] pim, input logic e_ov, input logic e_ir,
                       input longint e_re, input longint e_im, input logic e_of);
        vec_t x;
        x.v = v; x.c = c; x.r = r; x.pre = pre; x.pim = pim;
        x.e_ov = e_ov; x.e_ir = e_ir; x.e_re = e_re; x.e_im = e_im; x.e_of = e_of;
        tbl.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sat(input longint s);
        if (s > MAXV) begin m_ovf = 1'b1; return MAXV; end
        if (s < MINV) begin m_ovf = 1'b1; return MINV; end
        return s;
    endfunction

    function automatic longint acc_val(input logic [32:0] a);
        return longint'($signed(a));
    endfunction

    initial begin
        #2;
        chk("rst_out_valid", o_out_valid, 0);
        chk("rst_acc_re", acc_val(o_acc_re), 0);
        chk("rst_acc_im", acc_val(o_acc_im), 0);
        chk("rst_ovf", o_out_ovf, 0);
        #10 rst_n = 1'b1;
        step();
        chk("rst_in_ready", o_in_ready, 1);

        for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 2, 0, 1, 0, 0, 0);
        add(1, 0, 1, 1, 2, 1, 0, 4, 8, 0);
        add(0, 0, 1, 0, 0, 0, 1, 4, 8, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 2, 3, 0, 1, 4, 8, 0);
        add(1, 0, 0, 2, 3, 1, 0, 8, 12, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 0, 2, 3, 1, 0, 8, 12, 0);
        add(0, 0, 1, 0, 0, 0, 1, 8, 12, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, 8, 12, 0);
        add(1, 0, 1, 32'h7FFF_FFFF, 32'h8000_0000, 1, 0, MAXV, MINV, 1);
        add(0, 0, 1, 0, 0, 0, 1, MAXV, MINV, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 1, 1, 0, 1, MAXV, MINV, 0);
        add(1, 0, 1, 1, 1, 1, 0, 4, 4, 0);
        add(0, 0, 1, 0, 0, 0, 1, 4, 4, 0);
        for (int k = 0; k < 2; k++) add(1, 0, 0, 9, 9, 0, 1, 4, 4, 0);
        add(1, 1, 0, 9, 9, 0, 1, 4, 4, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 0, 3, 32'hFFFF_FFFF, 0, 1, 4, 4, 0);
        add(1, 0, 0, 3, 32'hFFFF_FFFF, 1, 0, 12, -4, 0);
        add(0, 1, 0, 0, 0, 0, 1, 12, -4, 0);
        for (int k = 0; k < 3; k++) add(1, 0, 1, 5, 5, 0, 1, 12, -4, 0);
        add(1, 0, 1, 5, 5, 1, 0, 20, 20, 0);
        add(0, 0, 1, 0, 0, 0, 1, 20, 20, 0);

        foreach (tbl[k]) begin
            i_in_valid = tbl[k].v; i_clear = tbl[k].c; i_out_ready = tbl[k].r;
            i_prod_re = tbl[k].pre; i_prod_im = tbl[k].pim;
            step();
            chk($sformatf("row%0d_out_valid", k), o_out_valid, tbl[k].e_ov);
            chk($sformatf("row%0d_in_ready", k), o_in_ready, tbl[k].e_ir);
            chk($sformatf("row%0d_acc_re", k), acc_val(o_acc_re), tbl[k].e_re);
            chk($sformatf("row%0d_acc_im", k), acc_val(o_acc_im), tbl[k].e_im);
            if (tbl[k].e_ov) chk($sformatf("row%0d_ovf", k), o_out_ovf, tbl[k].e_of);
        end
        i_clear = 1'b0;

        i_in_valid = 1'b1; i_out_ready = 1'b1; i_prod_re = 1; i_prod_im = 0;
        for (int k = 0; k < 3; k++) step();
        i_in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", o_out_valid, 0);
        chk("arst_in_ready", o_in_ready, 1);
        chk("arst_acc_re", acc_val(o_acc_re), 0);
        chk("arst_acc_im", acc_val(o_acc_im), 0);
        chk("arst_ovf", o_out_ovf, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        i_in_valid = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("arst_frame_valid", o_out_valid, 1);
        chk("arst_frame_re", acc_val(o_acc_re), 4);
        chk("arst_frame_im", acc_val(o_acc_im), 0);
        i_in_valid = 1'b0;
        step();
        chk("arst_frame_done", o_out_valid, 0);

        begin
            int accepts = 0, frames = 0, cyc = 0;
            logic [31:0] t_re, t_im;
            frame_t f;
            while ((accepts < 200 || exp_q.size() > 0) && cyc < 4000) begin
                t_re = $urandom(); t_im = $urandom();
                if ($urandom_range(0, 3) != 0) t_re = {{12{t_re[19]}}, t_re[19:0]};
                if ($urandom_range(0, 3) != 0) t_im = {{12{t_im[19]}}, t_im[19:0]};
                i_in_valid = (accepts < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
                i_out_ready = $urandom_range(0, 2) != 0;
                i_prod_re = t_re; i_prod_im = t_im;
                chk("rnd_in_ready", o_in_ready, !m_hold);
                chk("rnd_out_valid", o_out_valid, m_hold);
                if (m_hold && i_out_ready) begin
                    f = exp_q.pop_front();
                    chk("rnd_acc_re", acc_val(o_acc_re), f.re);
                    chk("rnd_acc_im", acc_val(o_acc_im), f.im);
                    chk("rnd_ovf", o_out_ovf, f.ovf);
                    frames++;
                    m_hold = 1'b0;
                end else if (!m_hold && i_in_valid) begin
                    m_re = sat(m_re + longint'($signed(t_re)));
                    m_im = sat(m_im + longint'($signed(t_im)));
                    accepts++;
                    m_cnt++;
                    if (m_cnt == N) begin
                        f.re = m_re; f.im = m_im; f.ovf = m_ovf;
                        exp_q.push_back(f);
                        m_re = 0; m_im = 0; m_ovf = 1'b0; m_cnt = 0;
                        m_hold = 1'b1;
                    end
                end
                step();
                cyc++;
            end
            if (cyc >= 4000) chk("rnd_timeout", cyc, 0);
            chk("rnd_frames", frames, accepts / N);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
